// File: rtl/alu_writeback_if.sv
// Bundle between the ALU and the execute/writeback stage: register read ports,
// flag outputs, result handshake and the clear-in-progress indicator.
interface alu_writeback_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [ADDR_W-1:0] rd_a_addr;
  logic [DATA_W-1:0] rd_a_data;
  logic [ADDR_W-1:0] rd_b_addr;
  logic [DATA_W-1:0] rd_b_data;
  logic              zero_flag;
  logic              carry_flag;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W:0]   in_result;
  logic              in_zero;
  logic              in_carry;
  logic              in_cond_met;
  logic              in_wr_en;
  logic              in_flags_en;
  logic [ADDR_W-1:0] in_dest;
  logic              busy;

  modport slave (
    input  rd_a_addr, rd_b_addr, in_valid, in_result, in_zero, in_carry,
           in_cond_met, in_wr_en, in_flags_en, in_dest,
    output rd_a_data, rd_b_data, zero_flag, carry_flag, in_ready, busy
  );

  modport master (
    output rd_a_addr, rd_b_addr, in_valid, in_result, in_zero, in_carry,
           in_cond_met, in_wr_en, in_flags_en, in_dest,
    input  rd_a_data, rd_b_data, zero_flag, carry_flag, in_ready, busy
  );
endinterface

// File: rtl/alu_writeback.sv
// Execute/writeback stage: register file, Z/C flags and a one-deep commit slot
// whose contents are forwarded to the read ports so dependent ops never stall.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | zeroing one register per cycle; in_ready=0, busy=1
//   ST_RUN   | accepting ALU results every cycle; left only through rst
module alu_writeback #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input logic           clk,
  input logic           rst,
  alu_writeback_if.slave wb
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              z_q;
  logic              c_q;
  logic              ready_q;
  logic              busy_q;

  logic              slot_vld_q;
  logic              slot_we_q;
  logic              slot_fe_q;
  logic              slot_z_q;
  logic              slot_c_q;
  logic [ADDR_W-1:0] slot_dest_q;
  logic [DATA_W-1:0] slot_data_q;

  logic              accept;
  logic              unused_result_carry;

  assign accept = wb.in_valid & ready_q;
  // The ALU carry-out bit of the result never reaches a register; C comes from in_carry.
  assign unused_result_carry = wb.in_result[DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      slot_vld_q <= 1'b0;
    end else begin
      slot_vld_q <= accept;
      if (accept) begin
        slot_dest_q <= wb.in_dest;
        slot_data_q <= wb.in_result[DATA_W-1:0];
        slot_z_q    <= wb.in_zero;
        slot_c_q    <= wb.in_carry;
        slot_we_q   <= wb.in_cond_met & wb.in_wr_en;
        slot_fe_q   <= wb.in_cond_met & wb.in_flags_en;
      end

      if (slot_vld_q && slot_we_q) begin
        regs_q[slot_dest_q] <= slot_data_q;
      end
      if (slot_vld_q && slot_fe_q) begin
        z_q <= slot_z_q;
        c_q <= slot_c_q;
      end

      case (state_q)
        ST_CLEAR: begin
          regs_q[clr_idx_q] <= '0;
          clr_idx_q         <= clr_idx_q + ADDR_W'(1);
          if (clr_idx_q == ADDR_W'(NUM_REGS - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  // A slot that is about to commit is the newest value, so it wins over the array.
  assign wb.rd_a_data  = (slot_vld_q && slot_we_q && (slot_dest_q == wb.rd_a_addr))
                         ? slot_data_q : regs_q[wb.rd_a_addr];
  assign wb.rd_b_data  = (slot_vld_q && slot_we_q && (slot_dest_q == wb.rd_b_addr))
                         ? slot_data_q : regs_q[wb.rd_b_addr];
  assign wb.zero_flag  = (slot_vld_q && slot_fe_q) ? slot_z_q : z_q;
  assign wb.carry_flag = (slot_vld_q && slot_fe_q) ? slot_c_q : c_q;
  assign wb.in_ready   = ready_q;
  assign wb.busy       = busy_q;
endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus random ops, all compared
// against an architectural model where an accepted op takes effect immediately.
module tb_alu_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_writeback_if #(.DATA_W(16), .NUM_REGS(8)) bus ();

  alu_writeback #(.DATA_W(16), .NUM_REGS(8)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Architectural view: everything accepted before the current cycle is visible.
  logic [15:0] m_regs [8];
  logic        m_z;
  logic        m_c;
  logic        m_ready;
  logic [2:0]  last_dest;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_result   = '0;
    bus.in_zero     = 1'b0;
    bus.in_carry    = 1'b0;
    bus.in_cond_met = 1'b0;
    bus.in_wr_en    = 1'b0;
    bus.in_flags_en = 1'b0;
    bus.in_dest     = '0;
  endtask

  // Called at a negedge; presents one op, advances one cycle, returns at the next negedge.
  task automatic step(input bit v, input logic [16:0] res, input bit z, input bit c,
                      input bit cm, input bit we, input bit fe, input logic [2:0] d);
    bus.in_valid    = v;
    bus.in_result   = res;
    bus.in_zero     = z;
    bus.in_carry    = c;
    bus.in_cond_met = cm;
    bus.in_wr_en    = we;
    bus.in_flags_en = fe;
    bus.in_dest     = d;
    @(posedge clk);
    if (v && m_ready && cm) begin
      if (we) m_regs[d] = res[15:0];
      if (fe) begin
        m_z = z;
        m_c = c;
      end
    end
    if (v && m_ready) last_dest = d;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic check_state(input logic [2:0] ra, input logic [2:0] rb);
    bus.rd_a_addr = ra;
    bus.rd_b_addr = rb;
    #1;
    chk("rd_a", bus.rd_a_data, m_regs[ra]);
    chk("rd_b", bus.rd_b_data, m_regs[rb]);
    chk("zero", bus.zero_flag, m_z);
    chk("carry", bus.carry_flag, m_c);
    chk("ready", bus.in_ready, m_ready);
    chk("busy", bus.busy, !m_ready);
  endtask

  task automatic check_reg(input logic [2:0] a);
    check_state(a, a);
  endtask

  // Called at a negedge. Garbage ops are offered during the clear; none may land.
  task automatic do_reset(input int cyc);
    int n;
    rst = 1'b1;
    idle_inputs();
    m_ready = 1'b0;
    repeat (cyc) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_ready", bus.in_ready, 1'b0);
    chk("rst_zero", bus.zero_flag, 1'b0);
    chk("rst_carry", bus.carry_flag, 1'b0);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.in_ready === 1'b1) break;
      n++;
      bus.in_valid    = 1'b1;
      bus.in_result   = 17'($urandom);
      bus.in_cond_met = 1'b1;
      bus.in_wr_en    = 1'b1;
      bus.in_flags_en = 1'b1;
      bus.in_zero     = 1'b1;
      bus.in_carry    = 1'b1;
      bus.in_dest     = 3'($urandom);
      @(negedge clk);
      #1;
    end
    idle_inputs();
    chk("clear_cycles", n, 8);
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_z = 1'b0;
    m_c = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) check_state(3'(i), 3'(7 - i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    bus.rd_a_addr = '0;
    bus.rd_b_addr = '0;
    last_dest = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_z = 1'b0;
    m_c = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    do_reset(3);

    // r3 write with carry: forwarded next cycle, then from the array
    step(1, 17'h01234, 0, 1, 1, 1, 1, 3'd3);
    check_reg(3'd3);
    chk("t2_byp_r3", bus.rd_a_data, 16'h1234);
    chk("t2_byp_c", bus.carry_flag, 1'b1);
    step(0, '0, 0, 0, 0, 0, 0, 3'd0);
    check_reg(3'd3);
    chk("t2_arr_r3", bus.rd_a_data, 16'h1234);
    chk("t2_arr_c", bus.carry_flag, 1'b1);

    // back-to-back writes to r1
    step(1, 17'h000FF, 0, 0, 1, 1, 0, 3'd1);
    check_reg(3'd1);
    chk("t3_first", bus.rd_a_data, 16'h00FF);
    step(1, 17'h0FF00, 0, 0, 1, 1, 0, 3'd1);
    check_reg(3'd1);
    chk("t3_second", bus.rd_b_data, 16'hFF00);
    step(0, '0, 0, 0, 0, 0, 0, 3'd0);
    check_reg(3'd1);
    chk("t3_final", bus.rd_a_data, 16'hFF00);

    // squashed op must change neither r2 nor flags
    step(1, 17'h05555, 1, 0, 1, 1, 1, 3'd2);
    step(1, 17'h0AAAA, 0, 1, 0, 1, 1, 3'd2);
    check_reg(3'd2);
    chk("t4_r2_byp", bus.rd_a_data, 16'h5555);
    chk("t4_z_byp", bus.zero_flag, 1'b1);
    step(0, '0, 0, 0, 0, 0, 0, 3'd0);
    check_reg(3'd2);
    chk("t4_r2_arr", bus.rd_a_data, 16'h5555);
    chk("t4_z_arr", bus.zero_flag, 1'b1);

    // carry-out bit of the result is not stored
    step(1, 17'h10000, 1, 1, 1, 1, 1, 3'd4);
    step(0, '0, 0, 0, 0, 0, 0, 3'd0);
    check_reg(3'd4);
    chk("t5_r4", bus.rd_a_data, 16'h0000);
    chk("t5_z", bus.zero_flag, 1'b1);
    chk("t5_c", bus.carry_flag, 1'b1);

    // reset while a write is still in the slot
    step(1, 17'h07777, 0, 1, 1, 1, 1, 3'd5);
    do_reset(1);
    check_reg(3'd5);
    chk("t6_r5", bus.rd_a_data, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 17'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom), 3'($urandom));
      if ($urandom_range(0, 1) == 1)
        check_state(last_dest, 3'($urandom));
      else
        check_state(3'($urandom), last_dest);
      if (i == 200) do_reset($urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
